// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared widths, constants and state enum for div_seq
package div_pkg;

    localparam int QW   = 10;                 // quotient / divisor / remainder width
    localparam int RW   = 20;                 // step numerator width
    localparam int BASE = 1000;               // one fractional group = three decimal digits

    localparam logic [QW-1:0] ERR_Q = 10'h3FF; // group value reported on divide-by-zero

    typedef enum logic {
        IDLE,
        OUT
    } state_t;

endpackage

// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - request and group stream handshake bundle for div_seq
//
// Request side : in_valid, in_ready, in_n, in_d
// Group side   : out_valid, out_ready, out_q, out_idx, out_last, out_err
// slave  modport : the divider
// master modport : whoever issues requests and consumes groups
interface div_seq_if #(
    parameter int IDXW = 2
);
    import div_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [QW-1:0]   in_n;
    logic [QW-1:0]   in_d;
    logic            out_valid;
    logic            out_ready;
    logic [QW-1:0]   out_q;
    logic [IDXW-1:0] out_idx;
    logic            out_last;
    logic            out_err;

    modport slave (
        input  in_valid, in_n, in_d, out_ready,
        output in_ready, out_valid, out_q, out_idx, out_last, out_err
    );

    modport master (
        output in_valid, in_n, in_d, out_ready,
        input  in_ready, out_valid, out_q, out_idx, out_last, out_err
    );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - combinational 10-quotient-bit restoring division step
//
// num : 20-bit dividend, caller guarantees num < d * 1024
// d   : 10-bit divisor
// q   : 10-bit quotient
// r   : 10-bit remainder
module div_step
    import div_pkg::*;
(
    input  logic [RW-1:0] num,
    input  logic [QW-1:0] d,
    output logic [QW-1:0] q,
    output logic [QW-1:0] r
);

    logic [QW:0] acc;

    always_comb begin
        // The upper half is already below d, so only QW quotient bits remain
        // and the partial remainder never needs more than QW+1 bits.
        acc = {1'b0, num[RW-1:QW]};
        q   = '0;
        for (int i = QW - 1; i >= 0; i--) begin
            acc = {acc[QW-1:0], num[i]};
            if (acc >= {1'b0, d}) begin
                acc  = acc - {1'b0, d};
                q[i] = 1'b1;
            end
        end
        r = acc[QW-1:0];
    end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - decimal long-division sequencer, one base-1000 group per cycle
//
// Ports: clk, rst (synchronous, active high), bus (div_seq_if.slave):
//   in_valid/in_ready/in_n/in_d    : division request
//   out_valid/out_ready/out_q      : group stream, integer group first
//   out_idx/out_last/out_err       : group index, final beat, divide-by-zero beat
// Build option: DIV_SEQ_ZERO_SKIP_EN ends the stream on the first group whose
// remainder is zero.
module div_seq
    import div_pkg::*;
#(
    parameter int GROUPS = 2,
    parameter int IDXW   = $clog2(GROUPS + 1)
) (
    input  logic         clk,
    input  logic         rst,
    div_seq_if.slave     bus
);

`ifdef DIV_SEQ_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    state_t          state;
    logic [QW-1:0]   d_reg;
    logic [QW-1:0]   rem;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [QW-1:0]   out_q_r;
    logic [IDXW-1:0] idx;
    logic            out_last_r;
    logic            out_err_r;

    logic [RW-1:0]   step_num;
    logic [QW-1:0]   step_d;
    logic [QW-1:0]   step_q;
    logic [QW-1:0]   step_r;
    logic [RW-1:0]   rem_x_base;
    logic [IDXW-1:0] idx_inc;
    logic            skip_hit;

    // rem < d, so rem*1000 < d*1000 < d*1024 keeps the step in range.
    assign rem_x_base = RW'(rem) * RW'(BASE);
    assign idx_inc    = idx + IDXW'(1);
    assign skip_hit   = ZERO_SKIP && (step_r == '0);

    // The single step is shared: IDLE divides the fresh numerator, OUT
    // divides the scaled remainder of the previous group.
    always_comb begin
        step_num = rem_x_base;
        step_d   = d_reg;
        if (state == IDLE) begin
            step_num = {{(RW-QW){1'b0}}, bus.in_n};
            step_d   = bus.in_d;
        end
    end

    div_step u_step (
        .num (step_num),
        .d   (step_d),
        .q   (step_q),
        .r   (step_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            d_reg       <= '0;
            rem         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_q_r     <= '0;
            idx         <= '0;
            out_last_r  <= 1'b0;
            out_err_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        d_reg       <= bus.in_d;
                        idx         <= '0;
                        in_ready_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= OUT;
                        if (bus.in_d == '0) begin
                            out_q_r    <= ERR_Q;
                            rem        <= '0;
                            out_err_r  <= 1'b1;
                            out_last_r <= 1'b1;
                        end else begin
                            out_q_r    <= step_q;
                            rem        <= step_r;
                            out_err_r  <= 1'b0;
                            out_last_r <= skip_hit;
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        if (out_last_r) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            out_err_r   <= 1'b0;
                            in_ready_r  <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            out_q_r    <= step_q;
                            rem        <= step_r;
                            idx        <= idx_inc;
                            out_last_r <= (idx_inc == IDXW'(GROUPS)) || skip_hit;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_q     = out_q_r;
    assign bus.out_idx   = idx;
    assign bus.out_last  = out_last_r;
    assign bus.out_err   = out_err_r;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed self-checking bench for div_seq
module tb_div_seq;

    localparam int GROUPS = 2;
    localparam int IDXW   = $clog2(GROUPS + 1);

`ifdef DIV_SEQ_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_seq_if #(.IDXW(IDXW)) bus ();

    div_seq #(.GROUPS(GROUPS), .IDXW(IDXW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;

    logic [9:0]      got_q    [16];
    logic [IDXW-1:0] got_idx  [16];
    logic            got_last [16];
    logic            got_err  [16];
    int              got_n;
    int              stall_bad;
    bit              timed_out;

    // Called at a negedge; presents one request for one cycle.
    task automatic send(input logic [9:0] n, input logic [9:0] d);
        int w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        bus.in_valid = 1'b1;
        bus.in_n     = n;
        bus.in_d     = d;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Consumes groups until out_last handshakes; returns one negedge later.
    task automatic collect(input bit toggle);
        logic [9:0]      sq;
        logic [IDXW-1:0] si;
        logic            sl;
        logic            se;
        bit              held;
        held      = 1'b0;
        sq        = '0;
        si        = '0;
        sl        = 1'b0;
        se        = 1'b0;
        got_n     = 0;
        stall_bad = 0;
        timed_out = 1'b1;
        for (int c = 0; c < 100; c++) begin
            bus.out_ready = toggle ? c[1] : 1'b1;
            if (held) begin
                if (bus.out_valid !== 1'b1 || bus.out_q !== sq || bus.out_idx !== si ||
                    bus.out_last !== sl || bus.out_err !== se)
                    stall_bad++;
            end
            held = 1'b0;
            if (bus.out_valid === 1'b1) begin
                if (bus.out_ready) begin
                    if (got_n < 16) begin
                        got_q[got_n]    = bus.out_q;
                        got_idx[got_n]  = bus.out_idx;
                        got_last[got_n] = bus.out_last;
                        got_err[got_n]  = bus.out_err;
                    end
                    got_n++;
                    if (bus.out_last === 1'b1) begin
                        @(negedge clk);
                        timed_out = 1'b0;
                        break;
                    end
                end else begin
                    held = 1'b1;
                    sq   = bus.out_q;
                    si   = bus.out_idx;
                    sl   = bus.out_last;
                    se   = bus.out_err;
                end
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_n      = '0;
        bus.in_d      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_q !== 10'd0 ||
            bus.out_idx !== '0 || bus.out_last !== 1'b0 || bus.out_err !== 1'b0)
            $display("FAIL reset: valid=%b ready=%b q=%0d idx=%0d last=%b err=%b required 0 1 0 0 0 0",
                     bus.out_valid, bus.in_ready, bus.out_q, bus.out_idx, bus.out_last, bus.out_err);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_division(input string name, input logic [9:0] n, input logic [9:0] d,
                                 input bit toggle, input int nexp,
                                 input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2);
        logic [9:0] exp_q [3];
        exp_q[0] = e0;
        exp_q[1] = e1;
        exp_q[2] = e2;
        send(n, d);
        checks++;
        if (bus.out_valid !== 1'b1)
            $display("FAIL %s latency: out_valid=%b required 1", name, bus.out_valid);
        else passed++;
        collect(toggle);
        checks++;
        if (timed_out || got_n != nexp)
            $display("FAIL %s beat_count: got %0d (timeout=%0b) required %0d", name, got_n, timed_out, nexp);
        else passed++;
        for (int i = 0; i < nexp && i < got_n; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_idx[i] !== IDXW'(i) ||
                got_last[i] !== (i == nexp - 1) || got_err[i] !== 1'b0)
                $display("FAIL %s beat%0d: q=%0d idx=%0d last=%b err=%b required q=%0d idx=%0d last=%b err=0",
                         name, i, got_q[i], got_idx[i], got_last[i], got_err[i],
                         exp_q[i], i, (i == nexp - 1));
            else passed++;
        end
        checks++;
        if (stall_bad != 0)
            $display("FAIL %s stall_stable: %0d unstable stall cycles required 0", name, stall_bad);
        else passed++;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL %s idle_after: in_ready=%b out_valid=%b required 1 0",
                     name, bus.in_ready, bus.out_valid);
        else passed++;
    endtask

    task automatic test_div_zero();
        send(10'd5, 10'd0);
        collect(1'b0);
        checks++;
        if (timed_out || got_n != 1)
            $display("FAIL div0 beat_count: got %0d required 1", got_n);
        else passed++;
        checks++;
        if (got_q[0] !== 10'h3FF || got_err[0] !== 1'b1 || got_last[0] !== 1'b1 || got_idx[0] !== '0)
            $display("FAIL div0 beat: q=%h err=%b last=%b idx=%0d required 3ff 1 1 0",
                     got_q[0], got_err[0], got_last[0], got_idx[0]);
        else passed++;
        test_division("after_div0", 10'd1, 10'd3, 1'b0, 3, 10'd0, 10'd333, 10'd333);
    endtask

    task automatic test_reset_mid();
        send(10'd22, 10'd7);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== IDXW'(1) || bus.out_q !== 10'd142)
            $display("FAIL midrst_setup: valid=%b idx=%0d q=%0d required 1 1 142",
                     bus.out_valid, bus.out_idx, bus.out_q);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_q !== 10'd0 || bus.out_idx !== '0)
            $display("FAIL midrst_abort: valid=%b ready=%b q=%0d idx=%0d required 0 1 0 0",
                     bus.out_valid, bus.in_ready, bus.out_q, bus.out_idx);
        else passed++;
        test_division("after_rst", 10'd1, 10'd4, 1'b0, ZS ? 2 : 3, 10'd0, 10'd250, 10'd0);
    endtask

    initial begin
        test_reset();
        test_division("n22_d7",   10'd22,   10'd7, 1'b0, 3,          10'd3,    10'd142, 10'd857);
        test_division("n1_d3",    10'd1,    10'd3, 1'b0, 3,          10'd0,    10'd333, 10'd333);
        test_division("n1023_d1", 10'd1023, 10'd1, 1'b0, ZS ? 1 : 3, 10'd1023, 10'd0,   10'd0);
        test_division("n10_d2",   10'd10,   10'd2, 1'b0, ZS ? 1 : 3, 10'd5,    10'd0,   10'd0);
        test_div_zero();
        test_division("n22_d7_bp", 10'd22,  10'd7, 1'b1, 3,          10'd3,    10'd142, 10'd857);
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Sequencer for decimal long division. It accepts a 10-bit numerator and denominator and streams the integer quotient followed by GROUPS fractional groups of three decimal digits (base-1000 digits, 0..999). It reuses one combinational 10-quotient-bit restoring-division step, one group per cycle. It sits between the pixel/scaling logic and the on-screen numeric text renderer, which consumes the groups over a valid/ready stream.

## Interface
Parameters:
- GROUPS, 2: number of fractional base-1000 groups after the integer group (1..8).
- IDXW, $clog2(GROUPS+1): width of out_idx.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block idle and able to accept.
- in_n  in  10  numerator, unsigned.
- in_d  in  10  denominator, unsigned.
- out_valid  out  1  group present on out_q.
- out_ready  in  1  consumer accepts the group.
- out_q  out  10  group value: integer part 0..1023; fractional 0..999.
- out_idx  out  IDXW  0 = integer group, k = k-th fractional group.
- out_last  out  1  final group of this division.
- out_err  out  1  divide-by-zero beat.

## Operation
- FSM states: IDLE, OUT.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - Latch d.
  - Run the step on numerator {10'b0,n}.
  - Register quotient into out_q and remainder into rem (10 bits).
  - Set idx=0 and go to OUT.
- OUT: out_valid=1. On out_valid&&out_ready:
  - If out_last, go to IDLE.
  - Otherwise run the step on rem*1000 (20 bits; always < d*1000), register the new quotient and remainder, and increment idx.
- Step: restoring division producing 10 quotient bits from a 20-bit numerator and 10-bit divisor. This is valid because the numerator is always < d*1024.
- out_last=1 when idx==GROUPS.
- d==0: enter OUT with a single beat: out_q=10'h3FF, out_err=1, out_last=1, idx=0. No further groups.
- Outputs stay stable while out_valid&&!out_ready.
- in_valid is ignored outside IDLE.
- Reset values: out_valid=0, out_q=0, out_idx=0, out_last=0, out_err=0, in_ready=1, state IDLE, rem=0.

## Timing
- Request accepted at cycle T → integer group valid at T+1.
- Group k+1 is valid the cycle after group k handshakes. Sustained throughput is one group per cycle with out_ready held high.
- Full division with no backpressure: GROUPS+1 output cycles. in_ready returns high the cycle after the last handshake.
- No input acceptance in the same cycle as the last output handshake.
- rst mid-division aborts immediately. Next cycle is IDLE with reset values, and no partial beats follow.
- Combinational path per cycle: 10 cascaded compare/subtract stages plus a ×1000 multiply. No pipelining inside the step.

## Configuration
- DIV_SEQ_ZERO_SKIP_EN defined: out_last is also asserted on any group whose post-step remainder is 0. The division terminates early; out_idx of that beat is less than or equal to GROUPS.
- Undefined: always exactly GROUPS+1 beats (zeros emitted), except on divide-by-zero.

## Structure
- Shared package div_pkg:
  - QW=10 and RW=20 widths.
  - BASE=1000 constant.
  - ERR_Q=10'h3FF.
  - State enum {IDLE, OUT}.
- One sub-module, div_step: combinational. Inputs num[19:0] and d[9:0]; outputs q[9:0] and r[9:0]. It has 10 restoring compare/subtract stages. Instantiated once.
- Everything else (FSM, rem, idx, output registers) lives in div_seq.

## Test plan
- n=22, d=7, GROUPS=2, out_ready=1 → beats 3, 142, 857 with idx 0,1,2; out_last on the third beat; in_ready high one cycle later.
- n=1, d=3 → 0, 333, 333. n=1023, d=1 → 1023, 0, 0.
- n=10, d=2 → without the macro: 5, 0, 0. With DIV_SEQ_ZERO_SKIP_EN: a single beat 5 with out_last=1, idx=0.
- d=0, n=5 → one beat out_q=3FF, out_err=1, out_last=1; the next request is accepted afterwards.
- n=22, d=7 with out_ready toggling 0/1 every two cycles → identical value sequence, outputs stable while stalled, no dropped or duplicated beats.
- rst asserted during the idx=1 beat → next cycle out_valid=0, in_ready=1. A new request n=1, d=4 then yields 0, 250, 0.
